// File: rtl/fft_frame_scheduler.sv
// Round-robin, frame-granular arbiter that shares one streaming FFT sink between NCH capture buffers.
// Define FFT_SCHED_TIMEOUT_EN to enable the first-sample watchdog (err_timeout_o); otherwise it is constant 0.
module fft_frame_scheduler #(
    parameter int W        = 16,
    parameter int NCH      = 2,
    parameter int NSAMPLES = 1024,
    parameter int GAP      = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         frame_req_i,
    output logic [NCH-1:0]         frame_start_o,
    input  logic [NCH*W-1:0]       ch_data_i,
    input  logic [NCH-1:0]         ch_valid_i,
    input  logic                   sink_ready_i,
    output logic [W-1:0]           fft_data_o,
    output logic                   fft_valid_o,
    output logic                   fft_sop_o,
    output logic                   fft_eop_o,
    output logic [$clog2(NCH)-1:0] fft_chan_o,
    output logic                   busy_o,
    output logic                   err_overrun_o,
    output logic                   err_stray_o,
    output logic                   err_timeout_o
);
    localparam int              CW        = $clog2(NCH);
    localparam int              NW        = $clog2(NSAMPLES) + 1;
    localparam logic [NW-1:0]   LAST_BEAT = NW'(NSAMPLES - 1);
    localparam logic [3:0]      GAP_LAST  = 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  chan_q, chan_d;
    logic [NW-1:0]  cnt_q, cnt_d;
    logic [3:0]     gcnt_q, gcnt_d;
    logic [NCH-1:0] start_q, start_d;
    logic [W-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           sop_q, sop_d;
    logic           eop_q, eop_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;
    logic           stray_q, stray_d;

    logic [CW-1:0]  grant_s;
    logic [CW-1:0]  idx_s;
    logic           beat_s;
    logic [W-1:0]   sample_s;
    logic           stray_s;

`ifdef FFT_SCHED_TIMEOUT_EN
    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   WD_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]  wd_q, wd_d;
    logic           timeout_q, timeout_d;
`endif

    assign beat_s   = ch_valid_i[chan_q];
    assign sample_s = ch_data_i[int'(chan_q) * W +: W];

    // Round-robin pick: nearest requester strictly after the pointer wins (descending scan, last hit kept).
    always_comb begin
        grant_s = ptr_q;
        idx_s   = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx_s = CW'((int'(ptr_q) + k) % NCH);
            if (frame_req_i[idx_s]) begin
                grant_s = idx_s;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Any valid beat that is not from the channel currently streaming is a stray.
    always_comb begin
        stray_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_valid_i[i] && ((state_q != S_STREAM) || (CW'(i) != chan_q))) begin
                stray_s = 1'b1;
            end else begin
                stray_s = stray_s;
            end
        end
    end

    // Next-state and registered-output logic for the grant/stream/gap sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        gcnt_d    = gcnt_q;
        start_d   = '0;
        data_d    = data_q;
        valid_d   = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        overrun_d = overrun_q;
        stray_d   = stray_q | stray_s;
`ifdef FFT_SCHED_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sink_ready_i && (|frame_req_i)) begin
                    state_d          = S_STREAM;
                    ptr_d            = grant_s;
                    chan_d           = grant_s;
                    start_d[grant_s] = 1'b1;
                    cnt_d            = '0;
`ifdef FFT_SCHED_TIMEOUT_EN
                    wd_d             = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (!sink_ready_i) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (beat_s) begin
                    valid_d = 1'b1;
                    data_d  = sample_s;
                    sop_d   = (cnt_q == '0);
                    if (cnt_q == LAST_BEAT) begin
                        eop_d   = 1'b1;
                        cnt_d   = '0;
                        gcnt_d  = '0;
                        state_d = (GAP == 0) ? S_IDLE : S_GAP;
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end else begin
`ifdef FFT_SCHED_TIMEOUT_EN
                    // Watchdog only runs while waiting for the first sample of the frame.
                    if (cnt_q == '0) begin
                        if (wd_q == WD_LAST) begin
                            timeout_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            wd_d = wd_q + TW'(1);
                        end
                    end else begin
                        wd_d = wd_q;
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any frame in flight and clears the sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= CW'(NCH - 1);
            chan_q    <= '0;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            start_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            chan_q    <= chan_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            start_q   <= start_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            stray_q   <= stray_d;
        end
    end

`ifdef FFT_SCHED_TIMEOUT_EN
    // Watchdog counter and its sticky flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign err_timeout_o = timeout_q;
`else
    assign err_timeout_o = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

    assign frame_start_o = start_q;
    assign fft_data_o    = data_q;
    assign fft_valid_o   = valid_q;
    assign fft_sop_o     = sop_q;
    assign fft_eop_o     = eop_q;
    assign fft_chan_o    = chan_q;
    assign busy_o        = busy_q;
    assign err_overrun_o = overrun_q;
    assign err_stray_o   = stray_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: frame-level behavioural model plus directed scenarios.
module tb_fft_frame_scheduler;
    localparam int W = 16, NCH = 2, N = 1024, GAP = 2, TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   frame_req = '0;
    logic [NCH-1:0]   frame_start;
    logic [NCH*W-1:0] ch_data = '0;
    logic [NCH-1:0]   ch_valid = '0;
    logic             sink_ready = 1'b0;
    logic [W-1:0]     fft_data;
    logic             fft_valid, fft_sop, fft_eop;
    logic [0:0]       fft_chan;
    logic             busy, err_overrun, err_stray, err_timeout;

    int checks = 0, errors = 0;

    // Model state
    logic             e_valid, e_sop, e_eop, e_busy, e_overrun, e_stray, e_timeout;
    logic [W-1:0]     e_data;
    logic [NCH-1:0]   e_fs;
    int               e_chan, m_ptr, m_chan, m_beats, m_gap, m_wd;
    logic             m_active;
    int               cur_len, last_len;
    int               order[$];

    fft_frame_scheduler #(.W(W), .NCH(NCH), .NSAMPLES(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .frame_req_i(frame_req), .frame_start_o(frame_start),
        .ch_data_i(ch_data), .ch_valid_i(ch_valid), .sink_ready_i(sink_ready),
        .fft_data_o(fft_data), .fft_valid_o(fft_valid), .fft_sop_o(fft_sop), .fft_eop_o(fft_eop),
        .fft_chan_o(fft_chan), .busy_o(busy),
        .err_overrun_o(err_overrun), .err_stray_o(err_stray), .err_timeout_o(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ramp(input int c, input int b);
        return W'(c * 4096 + b);
    endfunction

    function automatic int rr_pick(input logic [NCH-1:0] r, input int p);
        for (int k = 1; k <= NCH; k++) begin
            if (r[(p + k) % NCH]) return (p + k) % NCH;
        end
        return p;
    endfunction

    task automatic model_reset();
        e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_busy = 1'b0;
        e_overrun = 1'b0; e_stray = 1'b0; e_timeout = 1'b0;
        e_data = '0; e_fs = '0; e_chan = 0;
        m_ptr = NCH - 1; m_chan = 0; m_beats = 0; m_gap = 0; m_wd = 0; m_active = 1'b0;
        cur_len = 0;
    endtask

    // Compare process: check outputs against the model, then advance the model with the inputs about to be sampled.
    initial begin : compare
        logic [NCH-1:0] n_fs;
        logic           n_busy;
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) begin
                model_reset();
            end else begin
                chk("fft_valid", 32'(fft_valid), 32'(e_valid));
                if (e_valid) begin
                    chk("fft_data", 32'(fft_data), 32'(e_data));
                    chk("fft_sop", 32'(fft_sop), 32'(e_sop));
                    chk("fft_eop", 32'(fft_eop), 32'(e_eop));
                end
                chk("fft_chan", 32'(fft_chan), 32'(e_chan));
                chk("frame_start", 32'(frame_start), 32'(e_fs));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("err_overrun", 32'(err_overrun), 32'(e_overrun));
                chk("err_stray", 32'(err_stray), 32'(e_stray));
                chk("err_timeout", 32'(err_timeout), 32'(e_timeout));
                if (fft_valid) begin
                    if (fft_sop) cur_len = 0;
                    cur_len++;
                    chk("ramp_data", 32'(fft_data), 32'(ramp(int'(fft_chan), cur_len - 1)));
                    if (fft_eop) begin
                        last_len = cur_len;
                        order.push_back(int'(fft_chan));
                    end
                end

                for (int i = 0; i < NCH; i++) begin
                    if (ch_valid[i] && !(m_active && i == m_chan)) e_stray = 1'b1;
                end
                n_fs = '0; e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; n_busy = e_busy;
                if (!e_busy) begin
                    if (sink_ready && frame_req != '0) begin
                        m_chan = rr_pick(frame_req, m_ptr);
                        m_ptr = m_chan; n_fs[m_chan] = 1'b1; e_chan = m_chan;
                        m_active = 1'b1; m_beats = 0; m_wd = 0; n_busy = 1'b1;
                    end
                end else if (m_active) begin
                    if (!sink_ready) e_overrun = 1'b1;
                    if (ch_valid[m_chan]) begin
                        e_valid = 1'b1;
                        e_data = ch_data[m_chan * W +: W];
                        e_sop = (m_beats == 0);
                        e_eop = (m_beats == N - 1);
                        m_beats++;
                        if (m_beats == N) begin
                            m_active = 1'b0; m_beats = 0; m_gap = GAP; n_busy = (GAP > 0);
                        end
                    end
`ifdef FFT_SCHED_TIMEOUT_EN
                    else if (m_beats == 0) begin
                        m_wd++;
                        if (m_wd == TIMEOUT) begin
                            e_timeout = 1'b1; m_active = 1'b0; n_busy = 1'b0;
                        end
                    end
`endif
                end else begin
                    m_gap--;
                    n_busy = (m_gap > 0);
                end
                e_fs = n_fs;
                e_busy = n_busy;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        chk(name, 32'({frame_start, fft_data, fft_valid, fft_sop, fft_eop, fft_chan,
                       busy, err_overrun, err_stray, err_timeout}), 32'd0);
    endtask

    task automatic wait_fs(output int ch, output int lat, output logic [NCH-1:0] vec);
        ch = -1; lat = 0;
        while (frame_start == '0 && lat < 40) begin
            step();
            lat++;
        end
        vec = frame_start;
        if (frame_start == '0) chk("fs_wait_bound", 32'(frame_start), 32'd1);
        for (int i = 0; i < NCH; i++) if (frame_start[i]) ch = i;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        step();
        while (busy && t < 100) begin
            step();
            t++;
        end
        if (busy) chk("idle_wait_bound", 32'(busy), 32'd0);
        step();
    endtask

    // Stream one frame from channel ch; optional stray pulse, sink_ready dip, mid-frame reset, idle gaps.
    task automatic stream(input int ch, input int stray_at, input int srlow_at, input int reset_at, input int gap_every);
        int other;
        other = (ch + 1) % NCH;
        for (int b = 0; b < N; b++) begin
            if (b == reset_at) begin
                ch_valid = '0;
                reset = 1'b1;
                #1;
                check_zero("t5_async_reset");
                return;
            end
            sink_ready = !(srlow_at >= 0 && b >= srlow_at && b < srlow_at + 10);
            ch_data = {NCH{16'hBEEF}};
            ch_data[ch * W +: W] = ramp(ch, b);
            ch_valid = '0;
            ch_valid[ch] = 1'b1;
            if (b == stray_at) begin
                ch_valid[other] = 1'b1;
                ch_data[other * W +: W] = 16'hDEAD;
            end
            step();
            if (gap_every > 0 && b < N - 1 && (b % gap_every) == gap_every - 1) begin
                ch_valid = '0;
                step();
            end
        end
        ch_valid = '0;
        sink_ready = 1'b1;
    endtask

    initial begin : global_bound
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        int ch, lat, t;
        logic [NCH-1:0] vec;

        step(); step();
        check_zero("reset_state");
        reset = 1'b0;
        step();

        // 1: single channel frame with idle gaps in ch_valid
        sink_ready = 1'b1;
        frame_req = 2'b01;
        wait_fs(ch, lat, vec);
        chk("t1_fs_vec", 32'(vec), 32'h1);
        chk("t1_fs_latency", 32'(lat), 32'd1);
        frame_req = '0;
        stream(0, -1, -1, -1, 256);
        chk("t1_eop_visible", 32'(fft_eop), 32'd1);
        t = 0;
        while (busy && t < 50) begin
            step();
            t++;
        end
        chk("t1_busy_drop", 32'(t), 32'(GAP));
        chk("t1_len", 32'(last_len), 32'd1024);
        chk("t1_chan", 32'(order[order.size() - 1]), 32'd0);

        // 2: both channels requesting continuously from a fresh reset
        reset = 1'b1; step(); reset = 1'b0; step();
        frame_req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            wait_fs(ch, lat, vec);
            chk("t2_grant_order", 32'(ch), 32'(f % 2));
            if (f == 3) frame_req = '0;
            stream(ch, -1, -1, -1, 0);
        end
        wait_idle();
        chk("t2_len", 32'(last_len), 32'd1024);

        // 3: sink not ready holds the grant; dip during the frame flags overrun
        sink_ready = 1'b0;
        frame_req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold", 32'(frame_start), 32'd0);
        end
        sink_ready = 1'b1;
        step();
        chk("t3_grant", 32'(frame_start), 32'h1);
        frame_req = '0;
        stream(0, -1, 300, -1, 0);
        wait_idle();
        chk("t3_overrun", 32'(err_overrun), 32'd1);
        chk("t3_len", 32'(last_len), 32'd1024);

        // 4: stray pulse from ch1 while ch0 streams
        frame_req = 2'b01;
        wait_fs(ch, lat, vec);
        chk("t4_grant", 32'(ch), 32'd0);
        frame_req = '0;
        stream(0, 100, -1, -1, 0);
        wait_idle();
        chk("t4_stray", 32'(err_stray), 32'd1);
        chk("t4_len", 32'(last_len), 32'd1024);

        // 5: reset mid-frame, then a fresh frame
        frame_req = 2'b01;
        wait_fs(ch, lat, vec);
        frame_req = '0;
        stream(0, -1, -1, 500, 0);
        step(); step();
        reset = 1'b0;
        check_zero("t5_post_reset");
        step();
        frame_req = 2'b01;
        wait_fs(ch, lat, vec);
        chk("t5_grant", 32'(vec), 32'h1);
        frame_req = '0;
        stream(0, -1, -1, -1, 0);
        wait_idle();
        chk("t5_len", 32'(last_len), 32'd1024);

`ifdef FFT_SCHED_TIMEOUT_EN
        // 6: granted channel never streams; watchdog fires and the other channel is served
        reset = 1'b1; step(); reset = 1'b0; step();
        frame_req = 2'b11;
        wait_fs(ch, lat, vec);
        chk("t6_first", 32'(ch), 32'd0);
        t = 0;
        while (!err_timeout && t < 200) begin
            step();
            t++;
        end
        chk("t6_timeout_cycles", 32'(t), 32'(TIMEOUT));
        wait_fs(ch, lat, vec);
        chk("t6_second", 32'(ch), 32'd1);
        frame_req = '0;
        stream(1, -1, -1, -1, 0);
        wait_idle();
        chk("t6_len", 32'(last_len), 32'd1024);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
